cv32e40p_sleep_ctrl: RTL and testbench



---
 rtl/cv32e40p_pkg.sv | 17 +
 rtl/cv32e40p_txn_counter.sv | 47 ++++
 rtl/cv32e40p_sleep_ctrl.sv | 137 +++++++++++++
 tb/tb_cv32e40p_sleep_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_pkg.sv
// rtl/cv32e40p_pkg.sv - shared types and constants for the sleep controller
package cv32e40p_pkg;

    // Sleep controller FSM states
    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        SLEEP = 3'd3,
        WAKE  = 3'd4
    } sleep_state_e;

    // Largest wake-up delay the 4-bit delay counter can hold
    localparam int unsigned WAKEUP_DELAY_MAX = 15;
    localparam int unsigned WAKE_CNT_W       = 4;

endpackage

// File: rtl/cv32e40p_txn_counter.sv
// rtl/cv32e40p_txn_counter.sv - saturating in-flight bus transaction counter
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   issue, retire : one bus grant / one bus response this cycle
//   count         : registered in-flight count
//   zero          : count is zero
//   over_err      : issue-only while count is at MAX_OUTSTANDING (count holds)
//   under_err     : retire-only while count is zero (count holds)
module cv32e40p_txn_counter
    import cv32e40p_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             issue,
    input  logic             retire,
    output logic [CNT_W-1:0] count,
    output logic             zero,
    output logic             over_err,
    output logic             under_err
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic issue_only;
    logic retire_only;

    // Simultaneous issue and retire cancel out and can never be an error
    assign issue_only  = issue & ~retire;
    assign retire_only = retire & ~issue;

    assign zero      = (count == '0);
    assign over_err  = issue_only & (count == MAX_CNT);
    assign under_err = retire_only & zero;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
        end else if (issue_only && !over_err) begin
            count <= count + 1'b1;
        end else if (retire_only && !under_err) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/cv32e40p_sleep_ctrl.sv
// rtl/cv32e40p_sleep_ctrl.sv - core clock-gate enable and sleep/wake sequencing
//   clk_i          : free-running ungated clock
//   rst_ni         : asynchronous active-low reset
//   fetch_enable_i : boot request, only looked at in BOOT
//   wfi_req_i      : one-cycle pulse, core retired a WFI
//   core_busy_i    : pipeline still holds un-retired work
//   wake_irq_i     : enabled interrupt pending
//   debug_req_i    : debug halt request
//   txn_issue_i    : bus request granted this cycle
//   txn_retire_i   : bus response received this cycle
//   clock_en_o     : registered enable for the clock gate cell
//   core_sleep_o   : core asleep / not yet released
//   wake_o         : one-cycle pulse on WAKE -> RUN
//   outstanding_o  : in-flight bus transaction count
//   err_o          : sticky bus protocol error
module cv32e40p_sleep_ctrl
    import cv32e40p_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned WAKEUP_DELAY    = 2,
    parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             fetch_enable_i,
    input  logic             wfi_req_i,
    input  logic             core_busy_i,
    input  logic             wake_irq_i,
    input  logic             debug_req_i,
    input  logic             txn_issue_i,
    input  logic             txn_retire_i,
    output logic             clock_en_o,
    output logic             core_sleep_o,
    output logic             wake_o,
    output logic [CNT_W-1:0] outstanding_o,
    output logic             err_o
);

    // Out-of-range delays saturate rather than wrap in the 4-bit counter
    localparam logic [WAKE_CNT_W-1:0] WAKE_LOAD =
        (WAKEUP_DELAY > WAKEUP_DELAY_MAX) ? WAKE_CNT_W'(WAKEUP_DELAY_MAX)
                                          : WAKE_CNT_W'(WAKEUP_DELAY);

    sleep_state_e          state_q;
    sleep_state_e          state_d;
    logic [WAKE_CNT_W-1:0] dly_q;
    logic [WAKE_CNT_W-1:0] dly_d;
    logic                  wake_d;
    logic                  err_d;
    logic                  wake_req;
    logic                  bus_idle;
    logic                  cnt_zero;
    logic                  cnt_over;
    logic                  cnt_under;
    logic                  gated_txn;

    cv32e40p_txn_counter #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_txn_counter (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .issue     (txn_issue_i),
        .retire    (txn_retire_i),
        .count     (outstanding_o),
        .zero      (cnt_zero),
        .over_err  (cnt_over),
        .under_err (cnt_under)
    );

    assign wake_req = wake_irq_i | debug_req_i;
    // A grant in the same cycle would leave a transaction in flight once gated
    assign bus_idle = cnt_zero & ~core_busy_i & ~txn_issue_i;
    // Bus activity while the core clock is off means something upstream is broken
    assign gated_txn = ((state_q == SLEEP) || (state_q == BOOT)) &
                       (txn_issue_i | txn_retire_i);
    assign err_d = err_o | cnt_over | cnt_under | gated_txn;

    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        wake_d  = 1'b0;
        case (state_q)
            BOOT: begin
                if (fetch_enable_i) state_d = RUN;
            end
            RUN: begin
                // A WFI with a wake source already pending is a NOP
                if (wfi_req_i && !wake_req) state_d = DRAIN;
            end
            DRAIN: begin
                if (wake_req) begin
                    state_d = RUN;
                end else if (bus_idle) begin
                    state_d = SLEEP;
                end
            end
            SLEEP: begin
                if (wake_req) begin
                    state_d = WAKE;
                    dly_d   = WAKE_LOAD;
                end
            end
            WAKE: begin
                // Committed once entered; dropping the wake source does not abort
                if (dly_q == '0) begin
                    state_d = RUN;
                    wake_d  = 1'b1;
                end else begin
                    dly_d = dly_q - 1'b1;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // Outputs are decoded from the next state so they line up with state_q
    // and the gate enable never has a combinational path from an input.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= BOOT;
            dly_q        <= '0;
            clock_en_o   <= 1'b0;
            core_sleep_o <= 1'b1;
            wake_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            state_q      <= state_d;
            dly_q        <= dly_d;
            clock_en_o   <= (state_d == RUN) || (state_d == DRAIN) || (state_d == WAKE);
            core_sleep_o <= (state_d == BOOT) || (state_d == SLEEP) || (state_d == WAKE);
            wake_o       <= wake_d;
            err_o        <= err_d;
        end
    end

endmodule

// File: tb/tb_cv32e40p_sleep_ctrl.sv
// tb/tb_cv32e40p_sleep_ctrl.sv - self-checking bench for cv32e40p_sleep_ctrl
module tb_cv32e40p_sleep_ctrl;

    localparam int MAXO = 2;
    localparam int WD   = 2;
    localparam int CW   = $clog2(MAXO + 1);

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          fe = 1'b0, wfi = 1'b0, busy = 1'b0, irq = 1'b0, dbg = 1'b0;
    logic          iss = 1'b0, ret = 1'b0;
    logic          clock_en, core_sleep, wake, err;
    logic [CW-1:0] outstanding;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cv32e40p_sleep_ctrl #(
        .MAX_OUTSTANDING (MAXO),
        .WAKEUP_DELAY    (WD)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .fetch_enable_i (fe),
        .wfi_req_i      (wfi),
        .core_busy_i    (busy),
        .wake_irq_i     (irq),
        .debug_req_i    (dbg),
        .txn_issue_i    (iss),
        .txn_retire_i   (ret),
        .clock_en_o     (clock_en),
        .core_sleep_o   (core_sleep),
        .wake_o         (wake),
        .outstanding_o  (outstanding),
        .err_o          (err)
    );

    // Reference model: phases and a remaining-cycles count for the wake window
    localparam int P_BOOT = 0, P_RUN = 1, P_DRAIN = 2, P_SLEEP = 3, P_WAKE = 4;
    int m_phase, m_left, m_cnt;
    bit m_err, m_wake;

    function automatic bit m_clken(int ph);
        return (ph == P_RUN) || (ph == P_DRAIN) || (ph == P_WAKE);
    endfunction

    function automatic bit m_sleep(int ph);
        return (ph == P_BOOT) || (ph == P_SLEEP) || (ph == P_WAKE);
    endfunction

    task automatic model_reset();
        m_phase = P_BOOT; m_left = 0; m_cnt = 0; m_err = 0; m_wake = 0;
    endtask

    task automatic model_step();
        bit wk;
        int nxt;
        bit pulse;
        if (!rst_ni) begin
            model_reset();
            return;
        end
        wk = irq || dbg;
        nxt = m_phase;
        pulse = 0;
        if ((m_phase == P_BOOT || m_phase == P_SLEEP) && (iss || ret)) m_err = 1;
        case (m_phase)
            P_BOOT:  if (fe) nxt = P_RUN;
            P_RUN:   if (wfi && !wk) nxt = P_DRAIN;
            P_DRAIN: if (wk) nxt = P_RUN;
                     else if (m_cnt == 0 && !busy && !iss) nxt = P_SLEEP;
            P_SLEEP: if (wk) begin nxt = P_WAKE; m_left = WD + 1; end
            P_WAKE:  begin
                m_left--;
                if (m_left == 0) begin nxt = P_RUN; pulse = 1; end
            end
            default: nxt = P_BOOT;
        endcase
        if (iss && !ret) begin
            if (m_cnt == MAXO) m_err = 1; else m_cnt++;
        end else if (ret && !iss) begin
            if (m_cnt == 0) m_err = 1; else m_cnt--;
        end
        m_phase = nxt;
        m_wake = pulse;
    endtask

    // Inputs change after the falling edge; outputs are sampled at the next falling edge
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        fe = 0; wfi = 0; busy = 0; irq = 0; dbg = 0; iss = 0; ret = 0;
    endtask

    task automatic reset_and_boot();
        clear_inputs();
        rst_ni = 0; cyc(); rst_ni = 1;
        fe = 1; cyc(); fe = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_ni = 0;
        cyc(); cyc();
        n_checks++; if (clock_en !== 1'b0) begin n_fail++; $display("FAIL reset_clock_en: got %b expected 0", clock_en); end
        n_checks++; if (core_sleep !== 1'b1) begin n_fail++; $display("FAIL reset_core_sleep: got %b expected 1", core_sleep); end
        n_checks++; if (wake !== 1'b0) begin n_fail++; $display("FAIL reset_wake: got %b expected 0", wake); end
        n_checks++; if (outstanding !== '0) begin n_fail++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        rst_ni = 1;
    endtask

    task automatic test_boot();
        for (int c = 0; c < 3; c++) begin
            cyc();
            n_checks++; if (clock_en !== 1'b0 || core_sleep !== 1'b1) begin
                n_fail++; $display("FAIL boot_wait c=%0d: got en=%b sleep=%b expected en=0 sleep=1", c, clock_en, core_sleep);
            end
        end
        fe = 1; cyc(); fe = 0;
        for (int c = 0; c < 3; c++) begin
            n_checks++; if (clock_en !== 1'b1 || core_sleep !== 1'b0) begin
                n_fail++; $display("FAIL boot_run c=%0d: got en=%b sleep=%b expected en=1 sleep=0", c, clock_en, core_sleep);
            end
            cyc();
        end
    endtask

    task automatic test_drain_sleep();
        int exp_out;
        bit exp_en;
        iss = 1; cyc(); cyc(); iss = 0;
        n_checks++; if (outstanding !== CW'(2)) begin n_fail++; $display("FAIL drain_preload: got %0d expected 2", outstanding); end
        for (int k = 0; k < 8; k++) begin
            wfi = (k == 0);
            ret = (k == 2 || k == 5);
            cyc();
            wfi = 0; ret = 0;
            exp_en  = (k < 6);
            exp_out = (k < 2) ? 2 : (k < 5) ? 1 : 0;
            n_checks++; if (clock_en !== exp_en) begin n_fail++; $display("FAIL drain_clock_en k=%0d: got %b expected %b", k, clock_en, exp_en); end
            n_checks++; if (outstanding !== CW'(exp_out)) begin n_fail++; $display("FAIL drain_outstanding k=%0d: got %0d expected %0d", k, outstanding, exp_out); end
        end
        n_checks++; if (core_sleep !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL drain_asleep: got sleep=%b err=%b expected sleep=1 err=0", core_sleep, err); end
    endtask

    task automatic test_wake();
        for (int j = 0; j < 5; j++) begin
            irq = (j == 0);
            cyc();
            irq = 0;
            n_checks++; if (clock_en !== 1'b1) begin n_fail++; $display("FAIL wake_clock_en j=%0d: got %b expected 1", j, clock_en); end
            n_checks++; if (core_sleep !== (j <= 2)) begin n_fail++; $display("FAIL wake_core_sleep j=%0d: got %b expected %b", j, core_sleep, j <= 2); end
            n_checks++; if (wake !== (j == 3)) begin n_fail++; $display("FAIL wake_pulse j=%0d: got %b expected %b", j, wake, j == 3); end
        end
    endtask

    task automatic test_wfi_nop();
        wfi = 1; dbg = 1; cyc(); wfi = 0; dbg = 0;
        for (int c = 0; c < 4; c++) begin
            n_checks++; if (clock_en !== 1'b1 || core_sleep !== 1'b0) begin
                n_fail++; $display("FAIL wfi_nop c=%0d: got en=%b sleep=%b expected en=1 sleep=0", c, clock_en, core_sleep);
            end
            cyc();
        end
    endtask

    task automatic test_drain_abort();
        busy = 1; wfi = 1; cyc(); wfi = 0;
        cyc();
        irq = 1; cyc(); irq = 0; busy = 0;
        for (int c = 0; c < 4; c++) begin
            cyc();
            n_checks++; if (clock_en !== 1'b1 || wake !== 1'b0) begin
                n_fail++; $display("FAIL drain_abort c=%0d: got en=%b wake=%b expected en=1 wake=0", c, clock_en, wake);
            end
        end
    endtask

    task automatic test_overflow();
        int exp_out;
        for (int k = 0; k < 3; k++) begin
            iss = 1; cyc(); iss = 0;
            exp_out = (k < 2) ? k + 1 : 2;
            n_checks++; if (outstanding !== CW'(exp_out)) begin n_fail++; $display("FAIL ovf_outstanding k=%0d: got %0d expected %0d", k, outstanding, exp_out); end
            n_checks++; if (err !== (k == 2)) begin n_fail++; $display("FAIL ovf_err k=%0d: got %b expected %b", k, err, k == 2); end
        end
        ret = 1; cyc(); cyc(); ret = 0; cyc();
        n_checks++; if (outstanding !== '0 || err !== 1'b1) begin
            n_fail++; $display("FAIL ovf_sticky: got out=%0d err=%b expected out=0 err=1", outstanding, err);
        end
    endtask

    task automatic test_underflow();
        reset_and_boot();
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL unf_cleared: got %b expected 0", err); end
        ret = 1; cyc(); ret = 0;
        n_checks++; if (outstanding !== '0 || err !== 1'b1) begin
            n_fail++; $display("FAIL unf: got out=%0d err=%b expected out=0 err=1", outstanding, err);
        end
    endtask

    task automatic test_reset_in_wake();
        reset_and_boot();
        wfi = 1; cyc(); wfi = 0; cyc();
        n_checks++; if (clock_en !== 1'b0) begin n_fail++; $display("FAIL rw_sleep: got %b expected 0", clock_en); end
        irq = 1; cyc(); irq = 0;
        n_checks++; if (clock_en !== 1'b1 || core_sleep !== 1'b1) begin
            n_fail++; $display("FAIL rw_wake: got en=%b sleep=%b expected en=1 sleep=1", clock_en, core_sleep);
        end
        #2 rst_ni = 0;
        #1;
        model_reset();
        n_checks++; if (clock_en !== 1'b0 || core_sleep !== 1'b1 || wake !== 1'b0) begin
            n_fail++; $display("FAIL rw_async: got en=%b sleep=%b wake=%b expected en=0 sleep=1 wake=0", clock_en, core_sleep, wake);
        end
        cyc(); rst_ni = 1;
        for (int c = 0; c < 5; c++) begin
            cyc();
            n_checks++; if (clock_en !== 1'b0 || core_sleep !== 1'b1 || wake !== 1'b0) begin
                n_fail++; $display("FAIL rw_after c=%0d: got en=%b sleep=%b wake=%b expected en=0 sleep=1 wake=0", c, clock_en, core_sleep, wake);
            end
        end
    endtask

    task automatic test_random();
        clear_inputs();
        rst_ni = 0; cyc(); rst_ni = 1;
        for (int c = 0; c < 3000; c++) begin
            rst_ni = ($urandom_range(0, 199) != 0);
            fe   = ($urandom_range(0, 99) < 30);
            wfi  = ($urandom_range(0, 99) < 15);
            busy = ($urandom_range(0, 99) < 30);
            irq  = ($urandom_range(0, 99) < 8);
            dbg  = ($urandom_range(0, 99) < 4);
            iss  = ($urandom_range(0, 99) < 25);
            ret  = ($urandom_range(0, 99) < 25);
            cyc();
            n_checks++; if (clock_en !== m_clken(m_phase)) begin n_fail++; $display("FAIL rand_clock_en c=%0d: got %b expected %b", c, clock_en, m_clken(m_phase)); end
            n_checks++; if (core_sleep !== m_sleep(m_phase)) begin n_fail++; $display("FAIL rand_core_sleep c=%0d: got %b expected %b", c, core_sleep, m_sleep(m_phase)); end
            n_checks++; if (wake !== m_wake) begin n_fail++; $display("FAIL rand_wake c=%0d: got %b expected %b", c, wake, m_wake); end
            n_checks++; if (outstanding !== CW'(m_cnt)) begin n_fail++; $display("FAIL rand_outstanding c=%0d: got %0d expected %0d", c, outstanding, m_cnt); end
            n_checks++; if (err !== m_err) begin n_fail++; $display("FAIL rand_err c=%0d: got %b expected %b", c, err, m_err); end
        end
        clear_inputs();
        rst_ni = 1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_boot();
        test_drain_sleep();
        test_wake();
        test_wfi_nop();
        test_drain_abort();
        test_overflow();
        test_underflow();
        test_reset_in_wake();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
